// File: rtl/uart_pkg.sv
// uart_pkg: definitions shared by the UART transmit and receive paths.
//   parity_t   - parity mode selection (none / even / odd)
//   tx_state_t - transmitter frame states
//   LINE_IDLE  - level of an idle line (also the stop-bit level)
//   START_LVL  - level of the start bit
//   parity_bit - parity bit for a given mode and XOR of the data bits
package uart_pkg;

    typedef enum logic [1:0] {
        PAR_NONE,
        PAR_EVEN,
        PAR_ODD
    } parity_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } tx_state_t;

    localparam logic LINE_IDLE = 1'b1;
    localparam logic START_LVL = 1'b0;

    function automatic logic parity_bit(input parity_t mode, input logic data_xor);
        return (mode == PAR_ODD) ? ~data_xor : data_xor;
    endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// uart_baud_gen: modulo-CLKS_PER_BIT bit-period counter.
//   clk     - rising-edge clock
//   clr     - synchronous clear; restarts the bit period at count 0
//   bit_end - one-cycle pulse on the last cycle (count CLKS_PER_BIT-1) of a period
module uart_baud_gen #(
    parameter int unsigned CLKS_PER_BIT = 16
) (
    input  logic clk,
    input  logic clr,
    output logic bit_end
);

    localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);

    logic [CNT_W-1:0] cnt;

    assign bit_end = (cnt == CNT_W'(CLKS_PER_BIT - 1));

    always_ff @(posedge clk) begin
        if (clr || bit_end) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/uart_tx.sv
// uart_tx: UART serial transmitter.
//   clk      - rising-edge clock
//   RST      - synchronous, active-high reset
//   tx_data  - word to send, latched on accept (tx_valid && tx_ready)
//   tx_valid - tx_data is valid
//   tx_ready - transmitter accepts a word this cycle (IDLE, or last cycle of last stop bit)
//   tx       - registered serial line, idles high
//   busy     - a frame is in progress (start through final stop bit)
// Frame: start(0), DATA_BITS data bits LSB first, optional parity, STOP_BITS stop bits(1).
module uart_tx
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 16,
    parameter int unsigned DATA_BITS    = 8,
    parameter parity_t     PARITY       = PAR_NONE,
    parameter int unsigned STOP_BITS    = 1
) (
    input  logic                 clk,
    input  logic                 RST,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic                 tx,
    output logic                 busy
);

    localparam int unsigned IDX_W = $clog2(DATA_BITS);

    tx_state_t            state;
    tx_state_t            state_next;
    logic [DATA_BITS-1:0] shreg;
    logic                 par_bit;
    logic [IDX_W-1:0]     bit_idx;
    logic                 stop_cnt;
    logic                 bit_end;
    logic                 accept;
    logic                 last_data;
    logic                 last_stop;

    assign last_data = (bit_idx == IDX_W'(DATA_BITS - 1));
    assign last_stop = (stop_cnt == 1'(STOP_BITS - 1));

    // Ready in the final stop cycle lets the next frame start with no idle gap.
    assign tx_ready = !RST && ((state == ST_IDLE) ||
                               (state == ST_STOP && last_stop && bit_end));
    assign accept   = tx_valid && tx_ready;
    assign busy     = (state != ST_IDLE);

    uart_baud_gen #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .clk     (clk),
        .clr     (RST || accept),
        .bit_end (bit_end)
    );

    always_ff @(posedge clk) begin
        if (RST) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (accept) state_next = ST_START;
            end
            ST_START: begin
                if (bit_end) state_next = ST_DATA;
            end
            ST_DATA: begin
                if (bit_end && last_data) begin
                    state_next = (PARITY == PAR_NONE) ? ST_STOP : ST_PARITY;
                end
            end
            ST_PARITY: begin
                if (bit_end) state_next = ST_STOP;
            end
            ST_STOP: begin
                if (bit_end && last_stop) begin
                    state_next = accept ? ST_START : ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // tx is loaded with the level of the upcoming bit at each bit boundary,
    // so the line changes on the same edge as the state register.
    always_ff @(posedge clk) begin
        if (RST) begin
            tx       <= LINE_IDLE;
            shreg    <= '0;
            par_bit  <= 1'b0;
            bit_idx  <= '0;
            stop_cnt <= 1'b0;
        end else if (accept) begin
            tx       <= START_LVL;
            shreg    <= tx_data;
            par_bit  <= parity_bit(PARITY, ^tx_data);
            bit_idx  <= '0;
            stop_cnt <= 1'b0;
        end else if (bit_end) begin
            case (state)
                ST_START: begin
                    tx <= shreg[0];
                end
                ST_DATA: begin
                    if (last_data) begin
                        tx <= (PARITY == PAR_NONE) ? LINE_IDLE : par_bit;
                    end else begin
                        shreg   <= shreg >> 1;
                        tx      <= shreg[1];
                        bit_idx <= bit_idx + 1'b1;
                    end
                end
                ST_STOP: begin
                    tx <= LINE_IDLE;
                    if (!last_stop) stop_cnt <= stop_cnt + 1'b1;
                end
                default: begin
                    tx <= LINE_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/uart_tx.md
# uart_tx

UART serial transmitter: accepts one parallel data word per valid/ready handshake and serialises it onto a single line as start bit, data bits LSB first, optional parity and stop bit(s), each held for a fixed number of clock cycles. It is the transmit-side counterpart of the receive path's input synchroniser and sampler. It sits between the host-side data source and the `tx` pad. The line idles high, and consecutive frames may be sent back-to-back with no idle gap.

## Interface
- `CLKS_PER_BIT`, 16: clock cycles per bit period; legal range is 2 or more.
- `DATA_BITS`, 8: data bits per frame; legal range is 5 to 9.
- `PARITY`, `PAR_NONE`: `PAR_NONE`, `PAR_EVEN` or `PAR_ODD` (from `uart_pkg`).
- `STOP_BITS`, 1: 1 or 2.
- `clk`  in  1  single clock; all logic is rising-edge.
- `RST`  in  1  synchronous, active-high reset.
- `tx_data`  in  `DATA_BITS`  word to send; sampled only on accept.
- `tx_valid`  in  1  `tx_data` is valid.
- `tx_ready`  out  1  transmitter can accept a word this cycle.
- `tx`  out  1  serial line; idles high.
- `busy`  out  1  a frame is in progress (start through final stop bit).

## Operation
- Accept occurs when `tx_valid && tx_ready` at a rising edge. `tx_data` is latched into the shift register and parity is computed from the latched word.
- Frame order is START (0), `DATA_BITS` data bits LSB first, PARITY (if enabled), then `STOP_BITS` stop bits (1).
- Parity rules:
  - Even parity: the parity bit equals the XOR of the data bits.
  - Odd parity: the parity bit is the inverse of that XOR.
- FSM states are IDLE, START, DATA, PARITY, STOP.
  - IDLE → START on accept.
  - START → DATA after 1 bit period.
  - DATA → PARITY, or → STOP when parity is none, after `DATA_BITS` periods.
  - PARITY → STOP after 1 period.
  - STOP → START if an accept occurs in the final stop cycle; otherwise → IDLE.
- The bit-period counter counts 0..`CLKS_PER_BIT`-1. The bit index counter is sized by `$clog2(DATA_BITS)`; the stop counter counts 0..`STOP_BITS`-1.
- `tx_ready` is 1 in IDLE, and also in the last clock cycle of the last stop bit. It is 0 at all other times.
- `tx_data` and `tx_valid` changes while `tx_ready` is 0 have no effect on the frame in flight.
- `tx` is registered, so no combinational path exists from inputs to `tx`.

## Timing
- Reset values (while `RST` is high, and in the cycle following reset):
  - `tx` = 1, `busy` = 0, state = IDLE, all counters = 0.
  - `tx_ready` = 0 while `RST` is high, and 1 from the first cycle after `RST` deasserts.
- Latency: if the accept is at edge t, `tx` = 0 (start bit) from edge t+1 for `CLKS_PER_BIT` cycles.
- Frame length is F = 1 + `DATA_BITS` + (parity ? 1 : 0) + `STOP_BITS` bit periods, i.e. F·`CLKS_PER_BIT` cycles.
- `busy` rises at edge t+1 and falls at edge t+1+F·`CLKS_PER_BIT`, unless a back-to-back accept keeps it high.
- Back-to-back: an accept in the last stop cycle makes the next start bit begin on the very next cycle. There is zero idle gap.
- Reset mid-frame: at the next edge, `tx` = 1 and state = IDLE. The partial frame is abandoned and no further bits are emitted.
- `RST` and `tx_valid` asserted in the same cycle: reset wins and the word is not accepted.

## Structure
- `uart_pkg` (shared with the receiver) holds:
  - the `parity_t` enum (`PAR_NONE`, `PAR_EVEN`, `PAR_ODD`);
  - the `tx_state_t` enum;
  - the line-level constants `LINE_IDLE` = 1 and `START_LVL` = 0.
- Sub-module `uart_baud_gen` is a modulo-`CLKS_PER_BIT` counter.
  - It has a synchronous clear (asserted on accept and on reset) and produces a one-cycle `bit_end` pulse on count `CLKS_PER_BIT`-1.
  - The receiver reuses it.
- `uart_tx` contains the FSM, shift register, parity register, bit/stop counters and the `tx` output register.

## Test plan
- 8N1 with `CLKS_PER_BIT`=4; send 0xA5 → `tx` = 0,1,0,1,0,0,1,0,1,1, each level held 4 cycles. That is 40 cycles total, with `busy` high exactly 40 cycles.
- `PAR_EVEN`, send 0x07 → parity bit 1. `PAR_ODD`, send 0x07 → parity bit 0. `PAR_EVEN`, send 0x00 → parity bit 0.
- `tx_valid` held high with 0x55 then 0xAA → the second start bit begins the cycle right after the first stop bit, with no idle cycle. `tx_ready` pulses high only in the last stop cycle.
- Mid-frame, change `tx_data` to 0xFF and pulse `tx_valid` during DATA → the frame in flight is unchanged and no second frame is sent.
- Assert `RST` for one cycle during bit 3 of data → `tx` = 1 and `tx_ready` = 1 in the cycle after reset releases. A new word accepted then is sent correctly.
- `STOP_BITS`=2, `DATA_BITS`=7, send 0x7F → 1 start + 7 data + 2 stop. `tx_ready` is low through the first stop bit and high only in the final cycle of the second.
